// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, shift-add multiply over WIDTH cycles.
// Results are zero-extended to 2*WIDTH and held with their flags until consumed downstream.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [WIDTH-1:0]     operandA,
  input  logic [WIDTH-1:0]     operandB,
  input  logic [2:0]           operation,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zeroFlag,
  output logic                 carryFlag,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;
  localparam logic [SW-1:0] LAST_ITER = SW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] prod_q, prod_next, a_ext;
  logic [SW-1:0]      cnt_q;
  logic               accept;

  logic [2*WIDTH-1:0] alu_res;
  logic               alu_carry;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   shl_res, shr_res;
  logic [SW-1:0]      shamt;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // inReady is high only in IDLE and outValid only in DONE, so accept and
  // consume never share a cycle.
  assign accept    = inValid && inReady;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    inReady  = 1'b0;
    outValid = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        inReady = 1'b1;
        if (inValid) state_d = (operation == OP_MUL) ? S_MUL : S_DONE;
      end
      S_MUL: begin
        busy = 1'b1;
        if (cnt_q == LAST_ITER) state_d = S_DONE;
      end
      S_DONE: begin
        outValid = 1'b1;
        if (outReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle operations, evaluated on the live operands during accept.
  always_comb begin
    shamt     = operandB[SW-1:0];
    diff      = {1'b0, operandA} - {1'b0, operandB};
    shl_res   = operandA << shamt;
    shr_res   = operandA >> shamt;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (operation)
      OP_ADD: begin
        alu_res   = (2*WIDTH)'(operandA) + (2*WIDTH)'(operandB);
        alu_carry = alu_res[WIDTH];
      end
      OP_SUB: begin
        alu_res   = (2*WIDTH)'(diff[WIDTH-1:0]);
        alu_carry = diff[WIDTH];
      end
      OP_AND:  alu_res = (2*WIDTH)'(operandA & operandB);
      OP_OR:   alu_res = (2*WIDTH)'(operandA | operandB);
      OP_XOR:  alu_res = (2*WIDTH)'(operandA ^ operandB);
      OP_SHL:  alu_res = (2*WIDTH)'(shl_res);
      OP_SHR:  alu_res = (2*WIDTH)'(shr_res);
      default: alu_res = '0;
    endcase
  end

  assign a_ext     = (2*WIDTH)'(a_q);
  assign prod_next = prod_q + (b_q[cnt_q] ? (a_ext << cnt_q) : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      result    <= '0;
      zeroFlag  <= 1'b1;
      carryFlag <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q    <= operandA;
            b_q    <= operandB;
            prod_q <= '0;
            cnt_q  <= '0;
            if (operation != OP_MUL) begin
              result    <= alu_res;
              zeroFlag  <= (alu_res == '0);
              carryFlag <= alu_carry;
            end
          end
        end
        S_MUL: begin
          // The final iteration writes straight into result; no early exit on B==0.
          if (cnt_q == LAST_ITER) begin
            result    <= prod_next;
            zeroFlag  <= (prod_next == '0);
            carryFlag <= 1'b0;
          end else begin
            prod_q <= prod_next;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
